// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding, the default branch shadow and the counter ceiling.
package definesPkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FLUSH    = 2'd2
   } ctrl_state_t;

   localparam int          BR_SHADOW_DEF = 2;
   localparam logic [15:0] CNT_MAX       = 16'hFFFF;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_cnt16.sv
// Saturating 16-bit event counter with asynchronous clear.
// Once it reaches CNT_MAX it holds that value until cleared.
module sat_cnt16
   import definesPkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        en,
   output logic [15:0] cnt
);

   logic [15:0] cnt_q;

   // Count enabled events, sticking at the ceiling.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt_q <= 16'h0000;
      end else if (en && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + 16'd1;
      end else begin
         cnt_q <= cnt_q;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, taken-branch redirect and shadow flush,
// load-use stall insertion, plus stall/flush performance counters.
module pipe_hazard_ctrl
   import definesPkg::*;
#(
   parameter int BR_SHADOW = BR_SHADOW_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   input  logic        id_rx_valid,
   input  logic        id_ry_valid,
   input  logic [2:0]  id_rx,
   input  logic [2:0]  id_ry,
   input  logic        ex_valid,
   input  logic        ex_wr_en,
   input  logic        ex_is_load,
   input  logic [2:0]  ex_rd,
   input  logic        ex_br_taken,
   input  logic [15:0] ex_br_target,
   input  logic        mem_busy,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        id_ex_en,
   output logic        id_ex_bubble,
   output logic        if_id_flush,
   output logic        pc_load,
   output logic [15:0] pc_next,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt,
   output logic [1:0]  state
);

   localparam logic [2:0] SHD_RELOAD = 3'(BR_SHADOW - 1);
   localparam logic       MULTI_SHD  = (BR_SHADOW > 1);

   ctrl_state_t state_q, state_d;
   logic [2:0]  shd_q, shd_d;
   logic        br_taken_s, load_use_s, stall_inc_s, flush_inc_s;

   assign br_taken_s = ex_valid & ex_br_taken;
   assign load_use_s = ex_valid & ex_is_load & ex_wr_en & id_valid &
                       ((id_rx_valid & (id_rx == ex_rd)) | (id_ry_valid & (id_ry == ex_rd)));

   // Control outputs and next state; reset overrides everything combinationally.
   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      pc_load      = 1'b0;
      pc_next      = 16'h0000;
      state_d      = state_q;
      shd_d        = shd_q;
      stall_inc_s  = 1'b0;
      flush_inc_s  = 1'b0;
      if (reset) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         id_ex_bubble = 1'b1;
         if_id_flush  = 1'b1;
         state_d      = ST_RUN;
         shd_d        = 3'd0;
      end else if (mem_busy) begin
         // Freeze wins in every state; an EX branch stays put until memory is ready.
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_en    = 1'b0;
         state_d     = ST_MEM_WAIT;
         shd_d       = 3'd0;
         stall_inc_s = 1'b1;
      end else if (br_taken_s) begin
         pc_load      = 1'b1;
         pc_next      = ex_br_target;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         flush_inc_s  = 1'b1;
         state_d      = MULTI_SHD ? ST_FLUSH : ST_RUN;
         shd_d        = MULTI_SHD ? SHD_RELOAD : 3'd0;
      end else begin
         case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
               state_d = ST_RUN;
               if (load_use_s) begin
                  pc_en        = 1'b0;
                  if_id_en     = 1'b0;
                  id_ex_bubble = 1'b1;
                  stall_inc_s  = 1'b1;
               end else begin
                  stall_inc_s = 1'b0;
               end
            end
            ST_FLUSH: begin
               // The ID instruction is being discarded, so load-use does not matter here.
               if_id_flush = 1'b1;
               if (shd_q > 3'd1) begin
                  shd_d   = shd_q - 3'd1;
                  state_d = ST_FLUSH;
               end else begin
                  shd_d   = 3'd0;
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_RUN;
               shd_d   = 3'd0;
            end
         endcase
      end
   end

   // State and shadow counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         shd_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         shd_q   <= shd_d;
      end
   end

   assign state = state_q;

   sat_cnt16 u_stall_cnt (
      .clk (clk),
      .clr (reset),
      .en  (stall_inc_s),
      .cnt (stall_cnt)
   );

   sat_cnt16 u_flush_cnt (
      .clk (clk),
      .clr (reset),
      .en  (flush_inc_s),
      .cnt (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table through a scoreboard queue,
// then hand-written reset-abort and counter-saturation sequences.
module tb_pipe_hazard_ctrl;

   typedef struct packed {
      logic       idv;
      logic       rxv;
      logic       ryv;
      logic [2:0] rx;
      logic [2:0] ry;
      logic       exv;
      logic       wr;
      logic       ld;
      logic [2:0] rd;
      logic       br;
      logic [15:0] tgt;
      logic       busy;
   } in_t;

   typedef struct packed {
      logic       pe;
      logic       ie;
      logic       xe;
      logic       bb;
      logic       fl;
      logic       pl;
      logic [15:0] pn;
      logic [1:0] st;
   } ctl_t;

   typedef struct {
      in_t         i;
      ctl_t        o;
      logic [15:0] sc;
      logic [15:0] fc;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid, id_rx_valid, id_ry_valid;
   logic [2:0]  id_rx, id_ry, ex_rd;
   logic        ex_valid, ex_wr_en, ex_is_load, ex_br_taken, mem_busy;
   logic [15:0] ex_br_target;
   logic        pc_en, if_id_en, id_ex_en, id_ex_bubble, if_id_flush, pc_load;
   logic [15:0] pc_next, stall_cnt, flush_cnt;
   logic [1:0]  state;

   int   checks = 0;
   int   errors = 0;
   vec_t exp_q[$];
   vec_t vecs[$];

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.BR_SHADOW(2)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_rx_valid(id_rx_valid), .id_ry_valid(id_ry_valid),
      .id_rx(id_rx), .id_ry(id_ry),
      .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target), .mem_busy(mem_busy),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
      .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
      .pc_load(pc_load), .pc_next(pc_next),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
   );

   function automatic in_t mk_in(logic idv, logic rxv, logic ryv, logic [2:0] rx, logic [2:0] ry,
                                 logic exv, logic wr, logic ld, logic [2:0] rd, logic br,
                                 logic [15:0] tgt, logic busy);
      in_t r;
      r.idv = idv; r.rxv = rxv; r.ryv = ryv; r.rx = rx; r.ry = ry;
      r.exv = exv; r.wr = wr; r.ld = ld; r.rd = rd; r.br = br; r.tgt = tgt; r.busy = busy;
      return r;
   endfunction

   function automatic ctl_t mk_ctl(logic pe, logic ie, logic xe, logic bb, logic fl, logic pl,
                                   logic [15:0] pn, logic [1:0] st);
      ctl_t c;
      c.pe = pe; c.ie = ie; c.xe = xe; c.bb = bb; c.fl = fl; c.pl = pl; c.pn = pn; c.st = st;
      return c;
   endfunction

   function automatic ctl_t c_def(logic [1:0] st);
      return mk_ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, st);
   endfunction
   function automatic ctl_t c_lu();
      return mk_ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0);
   endfunction
   function automatic ctl_t c_br(logic [15:0] t, logic [1:0] st);
      return mk_ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, t, st);
   endfunction
   function automatic ctl_t c_fl();
      return mk_ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd2);
   endfunction
   function automatic ctl_t c_frz(logic [1:0] st);
      return mk_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, st);
   endfunction
   function automatic ctl_t c_rst();
      return mk_ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0);
   endfunction

   function automatic in_t i_idle();
      return mk_in(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0);
   endfunction
   function automatic in_t i_br(logic [15:0] t, logic busy);
      return mk_in(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, t, busy);
   endfunction

   function automatic vec_t row(in_t i, ctl_t o, int sc, int fc);
      vec_t v;
      v.i = i; v.o = o; v.sc = 16'(sc); v.fc = 16'(fc);
      return v;
   endfunction

   task automatic drive(input in_t i);
      id_valid = i.idv; id_rx_valid = i.rxv; id_ry_valid = i.ryv;
      id_rx = i.rx; id_ry = i.ry;
      ex_valid = i.exv; ex_wr_en = i.wr; ex_is_load = i.ld; ex_rd = i.rd;
      ex_br_taken = i.br; ex_br_target = i.tgt; mem_busy = i.busy;
   endtask

   task automatic check_pop(input string name);
      vec_t e;
      ctl_t a;
      a = {pc_en, if_id_en, id_ex_en, id_ex_bubble, if_id_flush, pc_load, pc_next, state};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty", name);
      end else begin
         e = exp_q.pop_front();
         if (a !== e.o) begin
            errors++;
            $display("FAIL %s ctl got %h exp %h", name, a, e.o);
         end
         checks++;
         if (stall_cnt !== e.sc) begin
            errors++;
            $display("FAIL %s stall_cnt got %h exp %h", name, stall_cnt, e.sc);
         end
         checks++;
         if (flush_cnt !== e.fc) begin
            errors++;
            $display("FAIL %s flush_cnt got %h exp %h", name, flush_cnt, e.fc);
         end
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      @(posedge clk);
      #1;
      drive(v.i);
      exp_q.push_back(v);
      @(negedge clk);
      check_pop(name);
   endtask

   initial begin
      in_t lu_ry3, lu_rx5, busy_only;
      reset = 1'b1;
      drive(i_idle());
      lu_ry3    = mk_in(1'b1, 1'b0, 1'b1, 3'd0, 3'd3, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 16'h0000, 1'b0);
      lu_rx5    = mk_in(1'b1, 1'b1, 1'b0, 3'd5, 3'd0, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 16'h0000, 1'b0);
      busy_only = mk_in(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1);

      vecs.push_back(row(i_idle(), c_def(2'd0), 0, 0));
      vecs.push_back(row(lu_ry3, c_lu(), 0, 0));
      vecs.push_back(row(i_idle(), c_def(2'd0), 1, 0));
      vecs.push_back(row(lu_rx5, c_lu(), 1, 0));
      vecs.push_back(row(mk_in(1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 16'h0000, 1'b0), c_def(2'd0), 2, 0));
      vecs.push_back(row(mk_in(1'b1, 1'b1, 1'b0, 3'd4, 3'd0, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 16'h0000, 1'b0), c_def(2'd0), 2, 0));
      vecs.push_back(row(mk_in(1'b0, 1'b1, 1'b1, 3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 16'h0000, 1'b0), c_def(2'd0), 2, 0));
      vecs.push_back(row(mk_in(1'b1, 1'b1, 1'b1, 3'd3, 3'd3, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 16'h0000, 1'b0), c_def(2'd0), 2, 0));
      vecs.push_back(row(mk_in(1'b1, 1'b1, 1'b1, 3'd6, 3'd6, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 16'h0000, 1'b0), c_def(2'd0), 2, 0));
      vecs.push_back(row(mk_in(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'h0099, 1'b0), c_def(2'd0), 2, 0));
      vecs.push_back(row(i_br(16'h0040, 1'b0), c_br(16'h0040, 2'd0), 2, 0));
      vecs.push_back(row(i_idle(), c_fl(), 2, 1));
      vecs.push_back(row(i_idle(), c_def(2'd0), 2, 1));
      vecs.push_back(row(mk_in(1'b1, 1'b0, 1'b1, 3'd0, 3'd3, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 16'h0200, 1'b0), c_br(16'h0200, 2'd0), 2, 1));
      vecs.push_back(row(lu_ry3, c_fl(), 2, 2));
      vecs.push_back(row(i_idle(), c_def(2'd0), 2, 2));
      vecs.push_back(row(i_br(16'h1234, 1'b0), c_br(16'h1234, 2'd0), 2, 2));
      vecs.push_back(row(i_br(16'h5678, 1'b0), c_br(16'h5678, 2'd2), 2, 3));
      vecs.push_back(row(i_idle(), c_fl(), 2, 4));
      vecs.push_back(row(i_idle(), c_def(2'd0), 2, 4));
      vecs.push_back(row(i_br(16'h0080, 1'b1), c_frz(2'd0), 2, 4));
      vecs.push_back(row(i_br(16'h0080, 1'b1), c_frz(2'd1), 3, 4));
      vecs.push_back(row(i_br(16'h0080, 1'b1), c_frz(2'd1), 4, 4));
      vecs.push_back(row(i_br(16'h0080, 1'b0), c_br(16'h0080, 2'd1), 5, 4));
      vecs.push_back(row(i_idle(), c_fl(), 5, 5));
      vecs.push_back(row(i_idle(), c_def(2'd0), 5, 5));
      vecs.push_back(row(i_br(16'h0010, 1'b0), c_br(16'h0010, 2'd0), 5, 5));
      vecs.push_back(row(busy_only, c_frz(2'd2), 5, 6));
      vecs.push_back(row(i_idle(), c_def(2'd1), 6, 6));
      vecs.push_back(row(i_idle(), c_def(2'd0), 6, 6));

      // Reset values while reset is held.
      @(negedge clk);
      exp_q.push_back(row(i_idle(), c_rst(), 0, 0));
      check_pop("reset_hold");
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int k = 0; k < vecs.size(); k++) begin
         apply(vecs[k], $sformatf("vec%0d", k));
      end

      // Reset asserted in the middle of a FLUSH cycle aborts it at once.
      apply(row(i_br(16'h0100, 1'b0), c_br(16'h0100, 2'd0), 6, 6), "rst_pre_br");
      apply(row(i_idle(), c_fl(), 6, 7), "rst_in_flush");
      #2;
      reset = 1'b1;
      #1;
      exp_q.push_back(row(i_idle(), c_rst(), 0, 0));
      check_pop("rst_async");
      @(posedge clk);
      #1;
      exp_q.push_back(row(i_idle(), c_rst(), 0, 0));
      check_pop("rst_held");
      reset = 1'b0;
      @(negedge clk);
      exp_q.push_back(row(i_idle(), c_def(2'd0), 0, 0));
      check_pop("rst_release");
      apply(row(i_idle(), c_def(2'd0), 0, 0), "rst_after");

      // Reset asserted during MEM_WAIT also aborts.
      apply(row(busy_only, c_frz(2'd0), 0, 0), "mw_enter");
      apply(row(busy_only, c_frz(2'd1), 1, 0), "mw_hold");
      #2;
      reset = 1'b1;
      #1;
      exp_q.push_back(row(busy_only, c_rst(), 0, 0));
      check_pop("mw_rst");
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(i_idle());
      @(negedge clk);
      exp_q.push_back(row(i_idle(), c_def(2'd0), 0, 0));
      check_pop("mw_release");

      // 65537 consecutive stall cycles saturate the stall counter.
      @(posedge clk);
      #1;
      drive(busy_only);
      for (int n = 0; n < 65537; n++) begin
         @(posedge clk);
      end
      #1;
      exp_q.push_back(row(busy_only, c_frz(2'd1), 65535, 0));
      check_pop("sat_reach");
      @(posedge clk);
      #1;
      exp_q.push_back(row(busy_only, c_frz(2'd1), 65535, 0));
      check_pop("sat_hold");
      drive(i_idle());
      @(negedge clk);
      exp_q.push_back(row(i_idle(), c_def(2'd1), 65535, 0));
      check_pop("sat_release");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter: BR_SHADOW, 2, number of cycles IF/ID is flushed after a taken branch (range 1..7).
REQ-002 SHALL have port: clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: id_valid, id_rx_valid, id_ry_valid  input  1 each  decode-stage instruction valid and operand-used flags.
REQ-005 SHALL have ports: id_rx, id_ry  input  3 each  decode-stage source register numbers.
REQ-006 SHALL have ports: ex_valid, ex_wr_en, ex_is_load  input  1 each  execute-stage valid, register-write and load flags.
REQ-007 SHALL have port: ex_rd  input  3  execute-stage destination register.
REQ-008 SHALL have ports: ex_br_taken  input  1; ex_br_target  input  16  branch resolved taken in EX, and its target.
REQ-009 SHALL have port: mem_busy  input  1  data memory not ready; freezes the pipeline.
REQ-010 SHALL have ports: pc_en, if_id_en, id_ex_en  output  1 each  pipeline register write enables.
REQ-011 SHALL have ports: id_ex_bubble, if_id_flush  output  1 each  clear valid bit of ID/EX, IF/ID.
REQ-012 SHALL have ports: pc_load  output  1; pc_next  output  16  PC redirect strobe and value.
REQ-013 SHALL have ports: stall_cnt, flush_cnt  output  16 each  performance counters; state  output  2  FSM state.

Function
REQ-014 SHALL implement FSM states RUN(0), MEM_WAIT(1), FLUSH(2); state 3 unused and SHALL return to RUN next cycle.
REQ-015 SHALL drive all control outputs combinationally from state and current inputs (same-cycle effect).
REQ-016 Default (RUN, no hazard): pc_en=if_id_en=id_ex_en=1, bubble=flush=pc_load=0, pc_next=0.
REQ-017 Priority in RUN: mem_busy > taken branch > load-use hazard.
REQ-018 mem_busy=1 (any state): pc_en=if_id_en=id_ex_en=0, no bubble, no flush, no pc_load; next state MEM_WAIT; stall_cnt +1.
REQ-019 MEM_WAIT: hold freeze while mem_busy=1; when mem_busy=0 evaluate RUN rules this same cycle and transition per them.
REQ-020 Taken branch = ex_valid & ex_br_taken: pc_load=1, pc_next=ex_br_target, if_id_flush=1, id_ex_bubble=1; flush_cnt +1; if BR_SHADOW>1 go FLUSH with shadow counter = BR_SHADOW-1, else stay RUN.
REQ-021 FLUSH: if_id_flush=1, enables as default; counter decrements each cycle; counter reaching 0 at this cycle's end returns RUN.
REQ-022 Valid taken branch while in FLUSH SHALL redirect again and reload the shadow counter to BR_SHADOW-1.
REQ-023 Load-use hazard = ex_valid & ex_is_load & ex_wr_en & id_valid & ((id_rx_valid & id_rx==ex_rd) | (id_ry_valid & id_ry==ex_rd)).
REQ-024 Load-use hazard: pc_en=0, if_id_en=0, id_ex_bubble=1, id_ex_en=1; one cycle only (bubble clears ex_is_load); stall_cnt +1.
REQ-025 Load-use in FLUSH SHALL be ignored (ID instruction is being flushed).
REQ-026 Taken branch during mem_busy SHALL be deferred (EX frozen) and executed the first cycle mem_busy=0.
REQ-027 Counters SHALL saturate at 16'hFFFF.

Reset
REQ-028 While reset=1: state=RUN, shadow counter=0, stall_cnt=flush_cnt=0, pc_en=if_id_en=id_ex_en=0, if_id_flush=1, id_ex_bubble=1, pc_load=0, pc_next=0.
REQ-029 Reset asserted mid-FLUSH or mid-MEM_WAIT SHALL abort immediately; first cycle after release is RUN with default outputs.

Structure
REQ-030 Enum ctrl_state_t and default BR_SHADOW SHALL live in definesPkg.
REQ-031 SHALL instantiate sub-module sat_cnt16 (enable, async clear, saturating 16-bit) twice for stall_cnt and flush_cnt.

Verification
REQ-032 ex load to r3, id reads r3 via Ry -> one cycle pc_en=0, id_ex_bubble=1; stall_cnt 0->1; next cycle defaults.
REQ-033 Taken branch target 16'h0040, BR_SHADOW=2 -> pc_load=1, pc_next=16'h0040, flush 2 cycles, state 0->2->0, flush_cnt=1.
REQ-034 mem_busy high 3 cycles with taken branch in EX -> 3 frozen cycles, stall_cnt=3, redirect on 4th cycle.
REQ-035 Load-use and taken branch same cycle -> branch response only, stall_cnt unchanged.
REQ-036 Reset pulse during FLUSH -> outputs at reset values, then RUN defaults; counters 0.
REQ-037 Force 65537 stalls -> stall_cnt holds 16'hFFFF.
